// File: rtl/alu_result_scanner.sv
// -----------------------------------------------------------------------------
// alu_result_scanner
//
// Display stage for the ALU test rig. Captures the 16-bit ALU result and the
// 5-bit flag vector on a strobe and time-multiplexes them onto a 4-digit
// common-anode seven-segment display (hex digits, rightmost = digit 0).
//
// Optional feature: define ALU_SCAN_LEADING_ZERO_BLANK_EN to blank leading
// zero digits on the result page (digit 0 is always shown).
//
// Parameters
//   REFRESH_DIV   clock cycles per digit period (>= 2)
//   BLANK_CYCLES  leading cycles of each digit period with all anodes off
//                 (< REFRESH_DIV)
//
// Ports
//   clock       in   system clock, rising edge
//   reset       in   synchronous, active-high
//   capture     in   one-cycle strobe: result/flags are valid
//   result[15:0] in  ALU output word
//   flags[4:0]  in   ALU flag vector
//   hold        in   level: blocks capture, lights dp on digit 3
//   show_flags  in   level: flags page instead of result page
//   captured    out  one-cycle pulse the cycle after an accepted capture
//   seg_n[7:0]  out  active-low segments {dp,g,f,e,d,c,b,a}
//   an_n[3:0]   out  active-low anodes, an_n[0] = rightmost digit
//   dbg_state   out  FSM state (0 = STARTUP, 1 = SCAN)
//
// Handshake: capture is a valid-only strobe with no ready. A strobe that
// arrives while hold is high is dropped, not deferred.
// -----------------------------------------------------------------------------
module alu_result_scanner #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        capture,
  input  logic [15:0] result,
  input  logic [4:0]  flags,
  input  logic        hold,
  input  logic        show_flags,
  output logic        captured,
  output logic [7:0]  seg_n,
  output logic [3:0]  an_n,
  output logic        dbg_state
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] TERM      = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYCLES);

  typedef enum logic {
    ST_STARTUP = 1'b0,
    ST_SCAN    = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    digit_q, digit_d;
  logic          page_q,  page_d;   // 1 = flags page
  logic [15:0]   res_q;
  logic [4:0]    flg_q;

  logic          tc;
  logic          load;
  logic [3:0]    nib;
  logic          blank;
  logic [7:0]    seg_d;
  logic [3:0]    an_d;

  assign dbg_state = state_q;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    s = 7'h7F;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign tc   = (presc_q == TERM);
  assign load = capture && !hold;

  // Next-state: prescaler, digit index and page latch.
  always_comb begin
    state_d = state_q;
    presc_d = tc ? '0 : presc_q + 1'b1;
    digit_d = digit_q;
    page_d  = page_q;
    case (state_q)
      ST_STARTUP: begin
        if (tc) begin
          state_d = ST_SCAN;
          digit_d = 2'd0;
          page_d  = show_flags;
        end
      end
      ST_SCAN: begin
        if (tc) begin
          digit_d = digit_q + 2'd1;
          page_d  = show_flags;
        end
      end
      default: begin
        state_d = ST_STARTUP;
        presc_d = '0;
        digit_d = 2'd0;
      end
    endcase
  end

  // Digit source. Uses the upcoming digit/page so the registered outputs line
  // up with the state they describe; uses the current capture register so a
  // new value appears one edge after it is loaded.
  always_comb begin
    nib   = 4'h0;
    blank = 1'b0;
    if (page_d) begin
      case (digit_d)
        2'd0:    nib = flg_q[3:0];
        2'd1:    nib = {3'b000, flg_q[4]};
        default: blank = 1'b1;
      endcase
    end else begin
      case (digit_d)
        2'd0:    nib = res_q[3:0];
        2'd1:    nib = res_q[7:4];
        2'd2:    nib = res_q[11:8];
        default: nib = res_q[15:12];
      endcase
`ifdef ALU_SCAN_LEADING_ZERO_BLANK_EN
      // A digit is a leading zero when it and every digit above it is zero.
      case (digit_d)
        2'd1:    blank = (res_q[15:4]  == 12'h000);
        2'd2:    blank = (res_q[15:8]  == 8'h00);
        2'd3:    blank = (res_q[15:12] == 4'h0);
        default: blank = 1'b0;
      endcase
`endif
    end
  end

  // Output next values.
  always_comb begin
    seg_d = 8'hFF;
    an_d  = 4'hF;
    if (state_d == ST_SCAN && !blank) begin
      seg_d[6:0] = hex7(nib);
      seg_d[7]   = !(digit_d == 2'd3 && hold);
      if (presc_d >= BLANK_END) begin
        an_d = ~(4'b0001 << digit_d);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_STARTUP;
      presc_q  <= '0;
      digit_q  <= 2'd0;
      page_q   <= 1'b0;
      res_q    <= 16'h0000;
      flg_q    <= 5'h00;
      captured <= 1'b0;
      seg_n    <= 8'hFF;
      an_n     <= 4'hF;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      digit_q  <= digit_d;
      page_q   <= page_d;
      captured <= load;
      if (load) begin
        res_q <= result;
        flg_q <= flags;
      end
      seg_n <= seg_d;
      an_n  <= an_d;
    end
  end

endmodule
